// File: rtl/common_types_pkg.sv
// rtl/common_types_pkg.sv - shared types for the RF front-end configuration sequencer
package common_types_pkg;

  localparam int FEM_CFG_IDX_W = 8;

  typedef enum logic [2:0] {
    FEM_IDLE      = 3'd0,
    FEM_POWERUP   = 3'd1,
    FEM_LOAD      = 3'd2,
    FEM_START     = 3'd3,
    FEM_WAIT_DONE = 3'd4,
    FEM_GAP       = 3'd5,
    FEM_DONE      = 3'd6,
    FEM_ERROR     = 3'd7
  } fem_cfg_state_t;

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - reloadable down-counter; expired while the count sits at zero
module cycle_timer #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // load has priority so a reload on the final counted cycle restarts cleanly
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/fem_config_seq.sv
// rtl/fem_config_seq.sv - writes the RF front-end register words through spi_tx after power-up
module fem_config_seq
  import common_types_pkg::*;
#(
  parameter int NUM_WORDS      = 5,
  parameter int WORD_WIDTH     = 32,
  parameter int POWERUP_CYCLES = 1920000,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int AUTO_START     = 1
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     cfg_req,
  output logic [FEM_CFG_IDX_W-1:0] cfg_idx,
  input  logic [WORD_WIDTH-1:0]    cfg_word,
  output logic [WORD_WIDTH-1:0]    spi_data,
  output logic                     spi_start,
  input  logic                     spi_busy,
  input  logic                     spi_done,
  output logic                     cfg_busy,
  output logic                     cfg_done,
  output logic                     cfg_err
);

  localparam int PU_W  = $clog2(POWERUP_CYCLES) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [PU_W-1:0]  PU_LOAD  = PU_W'(POWERUP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FEM_CFG_IDX_W-1:0] LAST_IDX = FEM_CFG_IDX_W'(NUM_WORDS - 1);

  localparam fem_cfg_state_t RESET_STATE = (AUTO_START != 0) ? FEM_POWERUP : FEM_IDLE;
  localparam logic           RESET_BUSY  = (AUTO_START != 0);

  fem_cfg_state_t           state_q, state_d;
  logic [FEM_CFG_IDX_W-1:0] idx_q, idx_d;
  logic [WORD_WIDTH-1:0]    data_q, data_d;
  logic                     start_q, busy_q, done_q, err_q;

  logic pu_load, gap_load, to_load;
  logic pu_expired, gap_expired, to_expired;

  // The power-up timer comes out of reset preloaded, so an auto-start needs no kick
  cycle_timer #(.WIDTH(PU_W), .RESET_VAL(PU_LOAD)) u_pu_timer (
    .clk     (clk),
    .nrst    (nrst),
    .load    (pu_load),
    .load_val(PU_LOAD),
    .en      (state_q == FEM_POWERUP),
    .expired (pu_expired)
  );

  cycle_timer #(.WIDTH(GAP_W), .RESET_VAL('0)) u_gap_timer (
    .clk     (clk),
    .nrst    (nrst),
    .load    (gap_load),
    .load_val(GAP_LOAD),
    .en      (state_q == FEM_GAP),
    .expired (gap_expired)
  );

  cycle_timer #(.WIDTH(TO_W), .RESET_VAL('0)) u_to_timer (
    .clk     (clk),
    .nrst    (nrst),
    .load    (to_load),
    .load_val(TO_LOAD),
    .en      ((state_q == FEM_START) || (state_q == FEM_WAIT_DONE)),
    .expired (to_expired)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    pu_load  = 1'b0;
    gap_load = 1'b0;
    to_load  = 1'b0;
    case (state_q)
      FEM_IDLE: begin
        if (cfg_req) begin
          state_d = FEM_POWERUP;
          idx_d   = '0;
          pu_load = 1'b1;
        end
      end
      FEM_POWERUP: begin
        if (pu_expired) state_d = FEM_LOAD;
      end
      FEM_LOAD: begin
        data_d  = cfg_word;
        state_d = FEM_START;
        to_load = 1'b1;
      end
      // A done pulse counts even before busy is seen, and beats a same-cycle timeout
      FEM_START, FEM_WAIT_DONE: begin
        if (spi_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = FEM_DONE;
          end else begin
            idx_d = idx_q + FEM_CFG_IDX_W'(1);
            if (GAP_CYCLES == 0) begin
              state_d = FEM_LOAD;
            end else begin
              state_d  = FEM_GAP;
              gap_load = 1'b1;
            end
          end
        end else if (to_expired) begin
          state_d = FEM_ERROR;
        end else if ((state_q == FEM_START) && spi_busy) begin
          state_d = FEM_WAIT_DONE;
        end
      end
      FEM_GAP: begin
        if (gap_expired) state_d = FEM_LOAD;
      end
      FEM_DONE, FEM_ERROR: begin
        if (cfg_req) begin
          state_d = FEM_POWERUP;
          idx_d   = '0;
          pu_load = 1'b1;
        end
      end
      default: state_d = FEM_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= RESET_STATE;
      idx_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= RESET_BUSY;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      start_q <= (state_d == FEM_START);
      busy_q  <= !(state_d inside {FEM_IDLE, FEM_DONE, FEM_ERROR});
      done_q  <= (state_d == FEM_DONE);
      err_q   <= (state_d == FEM_ERROR);
    end
  end

  assign cfg_idx   = idx_q;
  assign spi_data  = data_q;
  assign spi_start = start_q;
  assign cfg_busy  = busy_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

endmodule

// File: doc/fem_config_seq.md
Name: fem_config_seq

Overview:
- Sequences the RF front-end configuration. After power-up it writes NUM_WORDS register words through the existing spi_tx instance, one transfer at a time.
- Replaces ad-hoc word-counter/start logic in capture tops. Capture logic gates on cfg_done.
- Supports re-configuration on request and reports a transfer timeout as an error.
- Word contents are supplied externally through a combinational lookup indexed by cfg_idx.

Parameters:
NUM_WORDS, 5, number of configuration words per sequence (1..255)
WORD_WIDTH, 32, width of each SPI word
POWERUP_CYCLES, 1920000, clk cycles to wait after reset before the first word
GAP_CYCLES, 16, idle clk cycles between consecutive words (0 allowed)
TIMEOUT_CYCLES, 4096, max cycles in WAIT_BUSY or WAIT_DONE before error
AUTO_START, 1, 1 = run sequence automatically after reset; 0 = wait for cfg_req

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
cfg_req  input  1  pulse: (re)start sequence; honoured in IDLE, DONE, ERROR only
cfg_idx  output  8  index of the word being requested/sent
cfg_word  input  WORD_WIDTH  word for cfg_idx (combinational lookup outside)
spi_data  output  WORD_WIDTH  latched word to spi_tx data
spi_start  output  1  start request to spi_tx
spi_busy  input  1  spi_tx busy
spi_done  input  1  spi_tx single-cycle done pulse
cfg_busy  output  1  sequence in progress (any state except IDLE/DONE/ERROR)
cfg_done  output  1  all words sent successfully; sticky until next sequence/reset
cfg_err  output  1  timeout occurred; sticky until next sequence/reset

Behaviour:
- Reset (async, nrst=0): state = POWERUP if AUTO_START else IDLE. Power-up counter = 0, cfg_idx = 0, spi_data = 0, spi_start = 0, cfg_done = 0, cfg_err = 0. cfg_busy = 1 if AUTO_START else 0.
- Reset mid-transfer aborts immediately. The sequence restarts from POWERUP (with AUTO_START=1), or from IDLE to await cfg_req (with AUTO_START=0).
- States:
  - IDLE: cfg_req -> POWERUP.
  - POWERUP: count to POWERUP_CYCLES-1, then -> LOAD (exactly POWERUP_CYCLES cycles in state).
  - LOAD: spi_data <= cfg_word; -> START. One cycle; cfg_idx is stable throughout LOAD.
  - START: spi_start=1; timeout counter runs; -> WAIT_DONE when spi_busy=1. spi_start deasserts on the cycle spi_busy is first seen (registered: drops the following cycle).
  - WAIT_DONE: spi_start=0; on spi_done: if cfg_idx==NUM_WORDS-1 -> DONE, else cfg_idx+1 and -> GAP (or directly LOAD if GAP_CYCLES=0).
  - GAP: count GAP_CYCLES then -> LOAD.
  - DONE: cfg_done=1, cfg_busy=0; cfg_req -> clear cfg_done, cfg_idx=0, -> POWERUP.
  - ERROR: cfg_err=1, spi_start=0; cfg_req -> clear cfg_err, cfg_idx=0, -> POWERUP.
- Timeout: a single counter resets on entry to START and on leaving WAIT_DONE. It counts every cycle in START+WAIT_DONE; reaching TIMEOUT_CYCLES -> ERROR, with cfg_idx frozen at the failing word.
- spi_done while in START (transfer completed before busy seen) is treated as completion, same as WAIT_DONE.
- spi_done and timeout in the same cycle: done wins.
- cfg_req outside IDLE/DONE/ERROR is ignored (no queueing).
- spi_data changes only in LOAD, so it is stable for the whole transfer.
- cfg_idx width is 8 bits. Comparisons use NUM_WORDS-1 zero-extended. No wrap beyond NUM_WORDS-1.
- Counter widths are $clog2 of the respective parameter + 1.
- All outputs are registered.

Decomposition:
- Add fem_cfg_state_t enum (IDLE, POWERUP, LOAD, START, WAIT_DONE, GAP, DONE, ERROR) to common_types_pkg.
- Add FEM_CFG_IDX_W = 8 to common_types_pkg.
- Implement as a single module with a generic down-counter sub-module, cycle_timer (load, en, expired), reused for the POWERUP, GAP and timeout counts.
- The word lookup table stays outside this block.

Test Plan:
- Normal sequence (POWERUP_CYCLES=10, GAP=2, NUM_WORDS=5, spi_tx model: busy 1 cycle after start, done after 34 cycles) -> cfg_idx steps 0..4. spi_data equals the table word for each index. First spi_start at cycle 11 after reset release. cfg_done=1 after fifth done, with exactly 5 start assertions.
- AUTO_START=0 -> no spi_start for 100 cycles. Pulse cfg_req -> sequence runs as above. A second cfg_req while busy is ignored (still exactly 5 transfers).
- Timeout (TIMEOUT_CYCLES=20; model never asserts busy on word 2) -> ERROR at 20 cycles after START entry, cfg_err=1, cfg_idx=2, spi_start=0. Then cfg_req -> cfg_err=0 and a full rerun from idx 0.
- Reset asserted during word 3 transfer -> all outputs at reset values asynchronously. After release, sequence restarts at idx 0 after POWERUP_CYCLES.
- GAP_CYCLES=0 and a fast model (done in same cycle busy would be seen) -> no lost words, spi_start never asserted during LOAD. Done coinciding with timeout expiry -> advances, no error.
- Re-config from DONE via cfg_req -> cfg_done drops the next cycle, a second identical 5-word sequence follows, and cfg_done reasserts.
